// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive unstuff/deserialise path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        ERR  = 2'd2
    } rx_state_e;

    localparam logic [7:0] SYNC_PAT_DEFAULT = 8'h80;
    localparam int         USB_MAX_ONES     = 6;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Tracks the run of consecutive 1s and classifies each incoming bit as
// data, a stuffed 0 to drop, or a stuff error.
module usb_bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int MAX_ONES = USB_MAX_ONES
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic valid_i,
    input  logic load_i,
    input  logic clear_i,
    output logic data_bit_o,
    output logic data_valid_o,
    output logic stuff_err_o
);

    localparam int ONES_W = $clog2(MAX_ONES + 1);

    logic [ONES_W-1:0] ones_cnt_q;
    logic [ONES_W-1:0] ones_cnt_d;

    assign data_bit_o = bit_i;

    always_comb begin
        ones_cnt_d   = ones_cnt_q;
        data_valid_o = 1'b0;
        stuff_err_o  = 1'b0;
        if (clear_i) begin
            ones_cnt_d = '0;
        end else if (load_i) begin
            // The SYNC pattern ends in a 1, which starts the run.
            ones_cnt_d = ONES_W'(1);
        end else if (valid_i) begin
            if (ones_cnt_q == ONES_W'(MAX_ONES)) begin
                stuff_err_o = bit_i;
                ones_cnt_d  = '0;
            end else begin
                data_valid_o = 1'b1;
                ones_cnt_d   = bit_i ? ones_cnt_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_unstuff_deser.sv
// USB receive SYNC hunt, bit unstuffing and LSB-first byte deserialiser.
// Define USB_RX_STATS_EN to add saturating packet/error counter outputs.
module usb_rx_unstuff_deser
    import usb_rx_pkg::*;
#(
    parameter int         MAX_ONES = USB_MAX_ONES,
    parameter logic [7:0] SYNC_PAT = SYNC_PAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       eop,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       pkt_end,
    output logic       byte_err,
    output logic       stuff_err
`ifdef USB_RX_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
`endif
);

    rx_state_e   state_q, state_d;
    logic [7:0]  sync_sr_q, sync_sr_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        pkt_end_q, pkt_end_d;
    logic        byte_err_q, byte_err_d;
    logic        stuff_err_q, stuff_err_d;

    logic [7:0]  sr_next;
    logic        uns_valid, uns_load;
    logic        uns_bit, uns_data_valid, uns_err;

    // eop always wins over a coincident bit, so the bit never reaches the unstuffer.
    assign sr_next   = {bit_in, sync_sr_q[7:1]};
    assign uns_valid = (state_q == RECV) && bit_valid && !eop;
    assign uns_load  = (state_q == HUNT) && bit_valid && !eop && (sr_next == SYNC_PAT);

    usb_bit_unstuffer #(
        .MAX_ONES (MAX_ONES)
    ) u_unstuffer (
        .clk          (clk),
        .rst          (rst),
        .bit_i        (bit_in),
        .valid_i      (uns_valid),
        .load_i       (uns_load),
        .clear_i      (eop),
        .data_bit_o   (uns_bit),
        .data_valid_o (uns_data_valid),
        .stuff_err_o  (uns_err)
    );

    always_comb begin
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_end_d    = 1'b0;
        byte_err_d   = 1'b0;
        stuff_err_d  = 1'b0;
        case (state_q)
            HUNT: begin
                if (eop) begin
                    sync_sr_d = '0;
                end else if (bit_valid) begin
                    sync_sr_d = sr_next;
                    if (uns_load) begin
                        state_d   = RECV;
                        bit_cnt_d = '0;
                    end
                end
            end
            RECV: begin
                if (eop) begin
                    pkt_end_d  = 1'b1;
                    byte_err_d = (bit_cnt_q != 3'd0);
                    state_d    = HUNT;
                    sync_sr_d  = '0;
                    bit_cnt_d  = '0;
                end else if (uns_err) begin
                    stuff_err_d = 1'b1;
                    state_d     = ERR;
                    bit_cnt_d   = '0;
                end else if (uns_data_valid) begin
                    shift_d   = {uns_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_d   = shift_d;
                        byte_valid_d = 1'b1;
                    end
                end
            end
            ERR: begin
                if (eop) begin
                    state_d   = HUNT;
                    sync_sr_d = '0;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            sync_sr_q    <= 8'h00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            byte_err_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_sr_q    <= sync_sr_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_end_q    <= pkt_end_d;
            byte_err_q   <= byte_err_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign rx_active  = (state_q == RECV);
    assign pkt_end    = pkt_end_q;
    assign byte_err   = byte_err_q;
    assign stuff_err  = stuff_err_q;

`ifdef USB_RX_STATS_EN
    logic [15:0] pkt_count_q;
    logic [15:0] err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= 16'h0000;
            err_count_q <= 16'h0000;
        end else begin
            if (pkt_end_d && (pkt_count_q != 16'hFFFF)) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if ((stuff_err_d || (pkt_end_d && byte_err_d)) && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_usb_rx_unstuff_deser.sv
// Bench for usb_rx_unstuff_deser: directed packet scenarios plus random
// packets checked against a payload-level stuffing model.
module tb_usb_rx_unstuff_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       rx_active;
    logic       pkt_end;
    logic       byte_err;
    logic       stuff_err;
`ifdef USB_RX_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    usb_rx_unstuff_deser dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .eop        (eop),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .rx_active  (rx_active),
        .pkt_end    (pkt_end),
        .byte_err   (byte_err),
        .stuff_err  (stuff_err)
`ifdef USB_RX_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Passive monitor: collects every output event and pulse-rule violations.
    logic [7:0] got_bytes[$];
    logic       got_ends[$];
    int         got_stuff  = 0;
    int         pulse_viol = 0;
    logic       pbv = 1'b0, ppe = 1'b0, pse = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) got_bytes.push_back(byte_out);
            if (pkt_end) got_ends.push_back(byte_err);
            if (stuff_err) got_stuff <= got_stuff + 1;
            if ((byte_valid && pbv) || (pkt_end && ppe) || (stuff_err && pse) || (byte_valid && pkt_end))
                pulse_viol <= pulse_viol + 1;
        end
        pbv <= byte_valid;
        ppe <= pkt_end;
        pse <= stuff_err;
    end

    // One cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic b, input logic v, input logic e);
        bit_in    = b;
        bit_valid = v;
        eop       = e;
        @(posedge clk);
        #1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        eop       = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) drive(b[i], 1'b1, 1'b0);
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        got_ends.delete();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err} !== 13'd0) begin
            bad++;
            $display("FAIL reset_during got=%h exp=0", {byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if ({byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err} !== 13'd0) begin
            bad++;
            $display("FAIL reset_after got=%h exp=0", {byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err});
        end
        $display("test_reset done");
    endtask

    task automatic test_sync_byte();
        logic [7:0] b = 8'hA5;
        clear_mon();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
        total++;
        if (rx_active !== 1'b0) begin bad++; $display("FAIL sync_early rx_active got=%b exp=0", rx_active); end
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (rx_active !== 1'b1) begin bad++; $display("FAIL sync_match rx_active got=%b exp=1", rx_active); end
        for (int i = 0; i < 7; i++) drive(b[i], 1'b1, 1'b0);
        total++;
        if (byte_valid !== 1'b0) begin bad++; $display("FAIL a5_early byte_valid got=%b exp=0", byte_valid); end
        drive(b[7], 1'b1, 1'b0);
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hA5) begin
            bad++; $display("FAIL a5_byte valid=%b byte=%h exp valid=1 byte=a5", byte_valid, byte_out);
        end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (byte_valid !== 1'b0 || byte_out !== 8'hA5) begin
            bad++; $display("FAIL a5_hold valid=%b byte=%h exp valid=0 byte=a5", byte_valid, byte_out);
        end
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if (pkt_end !== 1'b1 || byte_err !== 1'b0 || rx_active !== 1'b0) begin
            bad++; $display("FAIL a5_eop pkt_end=%b byte_err=%b rx_active=%b exp 1 0 0", pkt_end, byte_err, rx_active);
        end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (pkt_end !== 1'b0) begin bad++; $display("FAIL a5_pkt_end_pulse got=%b exp=0", pkt_end); end
        $display("test_sync_byte done");
    endtask

    task automatic test_stuffing();
        int s0 = got_stuff;
        clear_mon();
        send_sync();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h7F) begin
            bad++; $display("FAIL stuff_byte valid=%b byte=%h exp valid=1 byte=7f", byte_valid, byte_out);
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (got_stuff !== s0 || got_ends.size() != 1 || got_ends[0] !== 1'b0) begin
            bad++; $display("FAIL stuff_clean stuff_errs=%0d ends=%0d exp 0 stuff_errs, 1 clean end", got_stuff - s0, got_ends.size());
        end
        $display("test_stuffing done");
    endtask

    task automatic test_stuff_err();
        clear_mon();
        send_sync();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (stuff_err !== 1'b1 || rx_active !== 1'b0) begin
            bad++; $display("FAIL serr_pulse stuff_err=%b rx_active=%b exp 1 0", stuff_err, rx_active);
        end
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (stuff_err !== 1'b0) begin bad++; $display("FAIL serr_one_cycle got=%b exp=0", stuff_err); end
        for (int i = 0; i < 8; i++) drive(1'(i % 2), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if (pkt_end !== 1'b0) begin bad++; $display("FAIL serr_no_pkt_end got=%b exp=0", pkt_end); end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (got_bytes.size() != 0 || got_ends.size() != 0) begin
            bad++; $display("FAIL serr_quiet bytes=%0d ends=%0d exp 0 0", got_bytes.size(), got_ends.size());
        end
        send_sync();
        send_byte(8'h55);
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h55) begin
            bad++; $display("FAIL serr_rehunt valid=%b byte=%h exp valid=1 byte=55", byte_valid, byte_out);
        end
        drive(1'b0, 1'b0, 1'b1);
        $display("test_stuff_err done");
    endtask

    task automatic test_partial();
        clear_mon();
        send_sync();
        send_byte(8'h3C);
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h3C) begin
            bad++; $display("FAIL part_byte valid=%b byte=%h exp valid=1 byte=3c", byte_valid, byte_out);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if (pkt_end !== 1'b1 || byte_err !== 1'b1) begin
            bad++; $display("FAIL part_eop pkt_end=%b byte_err=%b exp 1 1", pkt_end, byte_err);
        end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (got_bytes.size() != 1) begin bad++; $display("FAIL part_count bytes=%0d exp=1", got_bytes.size()); end
        $display("test_partial done");
    endtask

    task automatic test_async_reset();
        send_sync();
        send_byte(8'h5A);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (rx_active !== 1'b1 || byte_out !== 8'h5A) begin
            bad++; $display("FAIL arst_pre rx_active=%b byte=%h exp 1 5a", rx_active, byte_out);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err} !== 13'd0) begin
            bad++; $display("FAIL arst_immediate got=%h exp=0", {byte_out, byte_valid, rx_active, pkt_end, byte_err, stuff_err});
        end
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        send_sync();
        send_byte(8'hC3);
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hC3) begin
            bad++; $display("FAIL arst_fresh valid=%b byte=%h exp valid=1 byte=c3", byte_valid, byte_out);
        end
        drive(1'b0, 1'b0, 1'b1);
        $display("test_async_reset done");
    endtask

    task automatic test_gaps_collision();
        logic [7:0] b = 8'h96;
        logic [7:0] c = 8'h69;
        clear_mon();
        send_sync();
        for (int i = 0; i < 8; i++) begin
            repeat (3) drive(1'b1, 1'b0, 1'b0);
            drive(b[i], 1'b1, 1'b0);
        end
        total++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h96 || got_bytes.size() != 0) begin
            bad++; $display("FAIL gap_byte valid=%b byte=%h early=%0d exp valid=1 byte=96 early=0", byte_valid, byte_out, got_bytes.size());
        end
        drive(1'b0, 1'b0, 1'b1);
        send_sync();
        for (int i = 0; i < 7; i++) drive(c[i], 1'b1, 1'b0);
        drive(c[7], 1'b1, 1'b1);
        total++;
        if (pkt_end !== 1'b1 || byte_err !== 1'b1 || byte_valid !== 1'b0) begin
            bad++; $display("FAIL collide pkt_end=%b byte_err=%b byte_valid=%b exp 1 1 0", pkt_end, byte_err, byte_valid);
        end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (byte_valid !== 1'b0 || byte_out !== 8'h96) begin
            bad++; $display("FAIL collide_after valid=%b byte=%h exp valid=0 byte=96", byte_valid, byte_out);
        end
        $display("test_gaps_collision done");
    endtask

    // Random packets: payload is stuffed by the model (a 0 inserted after
    // every run of six 1s, the SYNC's final 1 included) and must come back intact.
    task automatic test_random();
        logic [7:0] exp_bytes[$];
        logic       data_bits[$];
        logic       tx_bits[$];
        int         s0 = got_stuff;
        for (int p = 0; p < 16; p++) begin
            int nb  = $urandom_range(0, 3);
            int res = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            int ones = 1;
            exp_bytes.delete();
            data_bits.delete();
            tx_bits.delete();
            for (int k = 0; k < nb; k++) begin
                int sel = $urandom_range(0, 3);
                logic [7:0] v = (sel == 0) ? 8'hFF : (sel == 1) ? 8'hFE : 8'($urandom_range(0, 255));
                exp_bytes.push_back(v);
                for (int i = 0; i < 8; i++) data_bits.push_back(v[i]);
            end
            for (int i = 0; i < res; i++) data_bits.push_back(1'($urandom_range(0, 1)));
            foreach (data_bits[i]) begin
                tx_bits.push_back(data_bits[i]);
                ones = data_bits[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    tx_bits.push_back(1'b0);
                    ones = 0;
                end
            end
            clear_mon();
            send_sync();
            foreach (tx_bits[i]) begin
                repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                drive(tx_bits[i], 1'b1, 1'b0);
            end
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (got_bytes.size() != nb) begin
                bad++; $display("FAIL rand_count pkt=%0d bytes=%0d exp=%0d", p, got_bytes.size(), nb);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    total++;
                    if (got_bytes[k] !== exp_bytes[k]) begin
                        bad++; $display("FAIL rand_byte pkt=%0d idx=%0d got=%h exp=%h", p, k, got_bytes[k], exp_bytes[k]);
                    end
                end
            end
            total++;
            if (got_ends.size() != 1 || got_ends[0] !== (res != 0)) begin
                bad++; $display("FAIL rand_end pkt=%0d ends=%0d exp 1 end with byte_err=%0b", p, got_ends.size(), res != 0);
            end
            $display("rand pkt %0d: %0d bytes, %0d residual bits, %0d line bits", p, nb, res, tx_bits.size());
        end
        total++;
        if (got_stuff !== s0) begin bad++; $display("FAIL rand_no_stuff_err got=%0d exp=0", got_stuff - s0); end
    endtask

    task automatic test_pulse_rules();
        total++;
        if (pulse_viol !== 0) begin bad++; $display("FAIL pulse_rules violations=%0d exp=0", pulse_viol); end
    endtask

    initial begin
        test_reset();
        test_sync_byte();
        test_stuffing();
        test_stuff_err();
        test_partial();
        test_async_reset();
        test_gaps_collision();
        test_random();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
